// File: rtl/eth_rx_frame_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// eth_rx_frame_buffer
//
// Single-frame receive buffer between an RMII byte deserializer and a 32-bit
// reader. The buffer collects one frame, packing bytes little-endian into
// 32-bit words, and latches the EtherType (bytes 12/13). It then holds the
// frame until the reader releases it with rx_clear. The reader sees the head
// word first-word-fall-through on rx_data and pops it with rx_read_en.
//
// Parameters
//   DEPTH_WORDS     32-bit word capacity of the frame store (power of two)
//   MIN_FRAME_BYTES shortest frame kept; shorter frames are discarded
//
// Compile-time option
//   ETH_RX_ERR_DROP_EN  when defined, a frame with in_err on any of its valid
//                       bytes is discarded at in_eof. When undefined, in_err
//                       is ignored.
//
// Ports
//   clk_100_mhz       system clock, rising edge
//   rst               asynchronous active-high reset
//   in_byte/in_valid  received byte and its qualifier
//   in_sof/in_eof     first / last byte of frame (qualified by in_valid)
//   in_err            PHY receive error for the current byte
//   rx_ready          a complete frame is held for readout
//   rx_data           head word, 0 when the store is empty
//   rx_read_en        pop head word
//   rx_empty          no unread words
//   rx_data_count     byte length of the held frame (0 unless holding)
//   rx_protocol_type  EtherType in [15:0] (0 unless holding)
//   rx_clear          release the held frame / abort reception
//   overflow          sticky: a frame exceeded DEPTH_WORDS*4 bytes
// -----------------------------------------------------------------------------
module eth_rx_frame_buffer #(
  parameter int unsigned DEPTH_WORDS     = 512,
  parameter int unsigned MIN_FRAME_BYTES = 14
) (
  input  logic        clk_100_mhz,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  output logic        rx_ready,
  output logic [31:0] rx_data,
  input  logic        rx_read_en,
  output logic        rx_empty,
  output logic [15:0] rx_data_count,
  output logic [31:0] rx_protocol_type,
  input  logic        rx_clear,
  output logic        overflow
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [15:0] CAP_BYTES = 16'(DEPTH_WORDS * 4);
  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME_BYTES);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_e;

  state_e      state_q;
  logic [AW:0] wr_ptr_q;    // words committed; one extra bit so a full store is distinguishable
  logic [AW:0] rd_ptr_q;
  logic [15:0] byte_cnt_q;  // index of the next byte within the frame
  logic [31:0] acc_q;       // partial word, unused lanes kept at zero
  logic [15:0] etype_q;
  logic        rx_ready_q;
  logic        overflow_q;
  logic [15:0] count_q;
  logic [15:0] ptype_q;
  logic [31:0] mem [DEPTH_WORDS];

  // Per-byte datapath. An in_sof byte always lands at index 0 with a clean
  // accumulator, which covers both a fresh frame and a restart mid-frame.
  logic        start;
  logic        accept;
  logic        overrun;
  logic        word_wr;
  logic        len_ok;
  logic        err_d;
  logic [15:0] idx;
  logic [31:0] word_d;
  logic [15:0] etype_d;

  assign start   = in_valid & in_sof;
  // rx_clear outranks any byte, including an in_sof byte in the same cycle.
  assign accept  = ~rx_clear & in_valid & ((state_q == IDLE & in_sof) | (state_q == RECV));
  assign overrun = (idx == CAP_BYTES);
  assign word_wr = accept & ~overrun & ((idx[1:0] == 2'b11) | in_eof);
  assign len_ok  = (idx + 16'd1) >= MIN_LEN;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value (which would infer a latch).
  always_comb begin
    idx     = start ? 16'd0 : byte_cnt_q;
    word_d  = start ? 32'd0 : acc_q;
    etype_d = start ? 16'd0 : etype_q;
    case (idx[1:0])
      2'd0:    word_d[7:0]   = in_byte;
      2'd1:    word_d[15:8]  = in_byte;
      2'd2:    word_d[23:16] = in_byte;
      default: word_d[31:24] = in_byte;
    endcase
    if (idx == 16'd12) etype_d[15:8] = in_byte;
    if (idx == 16'd13) etype_d[7:0]  = in_byte;
  end

`ifdef ETH_RX_ERR_DROP_EN
  logic err_q;
  assign err_d = (start ? 1'b0 : err_q) | in_err;
`else
  logic unused_in_err;
  assign unused_in_err = in_err;
  assign err_d         = 1'b0;
`endif

  // NOTE: the frame store has no reset; only the pointers decide what is
  // readable, so clearing the array would only cost a reset network.
  always_ff @(posedge clk_100_mhz) begin
    if (word_wr) mem[idx[AW+1:2]] <= word_d;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk_100_mhz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      etype_q    <= '0;
      rx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      ptype_q    <= '0;
`ifdef ETH_RX_ERR_DROP_EN
      err_q      <= 1'b0;
`endif
    end else if (rx_clear) begin
      // overflow is sticky and survives a clear.
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      etype_q    <= '0;
      rx_ready_q <= 1'b0;
      count_q    <= '0;
      ptype_q    <= '0;
    end else begin
      case (state_q)
        IDLE, RECV: begin
          if (accept) begin
            if (overrun) begin
              // Frame too long for the store: drop it and wait for a new in_sof.
              overflow_q <= 1'b1;
              state_q    <= IDLE;
              byte_cnt_q <= '0;
              acc_q      <= '0;
            end else begin
              etype_q <= etype_d;
`ifdef ETH_RX_ERR_DROP_EN
              err_q   <= err_d;
`endif
              if (in_eof) begin
                byte_cnt_q <= '0;
                acc_q      <= '0;
                if (len_ok && !err_d) begin
                  state_q    <= HOLD;
                  wr_ptr_q   <= {1'b0, idx[AW+1:2]} + PTR_ONE;
                  rx_ready_q <= 1'b1;
                  count_q    <= idx + 16'd1;
                  ptype_q    <= etype_d;
                end else begin
                  state_q <= IDLE;
                end
              end else begin
                state_q    <= RECV;
                byte_cnt_q <= idx + 16'd1;
                acc_q      <= word_wr ? 32'd0 : word_d;
              end
            end
          end
        end
        HOLD: begin
          if (rx_read_en && !rx_empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_empty         = (rd_ptr_q == wr_ptr_q);
  assign rx_data          = rx_empty ? 32'd0 : mem[rd_ptr_q[AW-1:0]];
  assign rx_ready         = rx_ready_q;
  assign rx_data_count    = count_q;
  assign rx_protocol_type = {16'h0000, ptype_q};
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_eth_rx_frame_buffer
//
// Drives frames into eth_rx_frame_buffer (store of 16 words, so a 64-byte
// frame fills it exactly). A frame-level reference model decides whether each
// frame should be kept. For kept frames it pushes the expected length,
// EtherType and packed words into queues. A monitor on the falling edge pops
// those expectations whenever the DUT presents a frame or a word.
// -----------------------------------------------------------------------------
module tb_eth_rx_frame_buffer;

  localparam int DEPTH = 16;
  localparam int MINB  = 14;
  localparam int CAP   = DEPTH * 4;

  logic        clk_100_mhz;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_sof;
  logic        in_eof;
  logic        in_err;
  logic        rx_ready;
  logic [31:0] rx_data;
  logic        rx_read_en;
  logic        rx_empty;
  logic [15:0] rx_data_count;
  logic [31:0] rx_protocol_type;
  logic        rx_clear;
  logic        overflow;

  eth_rx_frame_buffer #(
    .DEPTH_WORDS     (DEPTH),
    .MIN_FRAME_BYTES (MINB)
  ) dut (
    .clk_100_mhz      (clk_100_mhz),
    .rst              (rst),
    .in_byte          (in_byte),
    .in_valid         (in_valid),
    .in_sof           (in_sof),
    .in_eof           (in_eof),
    .in_err           (in_err),
    .rx_ready         (rx_ready),
    .rx_data          (rx_data),
    .rx_read_en       (rx_read_en),
    .rx_empty         (rx_empty),
    .rx_data_count    (rx_data_count),
    .rx_protocol_type (rx_protocol_type),
    .rx_clear         (rx_clear),
    .overflow         (overflow)
  );

  initial clk_100_mhz = 1'b0;
  always #5 clk_100_mhz = ~clk_100_mhz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [15:0] count;
    logic [15:0] etype;
  } frame_exp_t;

  frame_exp_t  exp_frames[$];
  logic [31:0] exp_words[$];
  bit          model_holding = 1'b0;
  bit          exp_overflow  = 1'b0;
  logic [7:0]  fb[$];   // bytes of the frame about to be driven
  bit          fe[$];   // in_err flag per byte

  // Returns 1 when the frame is expected to be held for readout.
  function automatic bit model_frame(input bit with_eof, input bit clear_first);
    int len;
    frame_exp_t f;
    logic [31:0] w;
    len = fb.size();
    if (model_holding || clear_first) return 1'b0;
    if (len > CAP) begin
      exp_overflow = 1'b1;
      return 1'b0;
    end
    if (!with_eof || len < MINB) return 1'b0;
`ifdef ETH_RX_ERR_DROP_EN
    begin
      bit any_err;
      any_err = 1'b0;
      foreach (fe[i]) any_err |= fe[i];
      if (any_err) return 1'b0;
    end
`endif
    f.count = 16'(len);
    f.etype = {fb[12], fb[13]};
    exp_frames.push_back(f);
    for (int wi = 0; wi < (len + 3) / 4; wi++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++)
        if (wi * 4 + b < len) w = w | (32'(fb[wi * 4 + b]) << (8 * b));
      exp_words.push_back(w);
    end
    model_holding = 1'b1;
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic        prev_ready = 1'b0;
  logic [15:0] cur_count  = '0;
  logic [15:0] cur_type   = '0;

  always @(negedge clk_100_mhz) begin
    frame_exp_t f;
    if (rx_ready && !prev_ready) begin
      if (exp_frames.size() == 0) check("unexpected_frame", {31'd0, rx_ready}, 32'd0);
      else begin
        f         = exp_frames.pop_front();
        cur_count = f.count;
        cur_type  = f.etype;
      end
    end
    if (rx_ready) begin
      check("data_count", {16'd0, rx_data_count}, {16'd0, cur_count});
      check("protocol_type", rx_protocol_type, {16'd0, cur_type});
      if (!rx_empty) begin
        if (exp_words.size() == 0) check("unexpected_word", {31'd0, rx_empty}, 32'd1);
        else begin
          check("rx_data", rx_data, exp_words[0]);
          if (rx_read_en) void'(exp_words.pop_front());
        end
      end
    end else begin
      check("idle_count", {16'd0, rx_data_count}, 32'd0);
      check("idle_type", rx_protocol_type, 32'd0);
    end
    prev_ready = rx_ready;
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    in_err   = 1'b0;
    rx_clear = 1'b0;
  endtask

  task automatic build_seq(input int len);
    fb.delete();
    fe.delete();
    for (int i = 0; i < len; i++) begin
      fb.push_back(8'(i));
      fe.push_back(1'b0);
    end
  endtask

  task automatic build_rand(input int len);
    fb.delete();
    fe.delete();
    for (int i = 0; i < len; i++) begin
      fb.push_back(8'($urandom_range(0, 255)));
      fe.push_back(1'b0);
    end
  endtask

  task automatic drive_frame(input bit with_eof, input bit clear_first, input bit gaps);
    for (int i = 0; i < fb.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk_100_mhz); #1;
        idle_inputs();
        in_byte = 8'($urandom_range(0, 255));
        in_sof  = 1'($urandom_range(0, 1));
      end
      @(posedge clk_100_mhz); #1;
      in_valid = 1'b1;
      in_byte  = fb[i];
      in_sof   = (i == 0);
      in_eof   = with_eof && (i == fb.size() - 1);
      in_err   = fe[i];
      rx_clear = clear_first && (i == 0);
    end
    @(posedge clk_100_mhz); #1;
    idle_inputs();
  endtask

  // rx_ready must be up on the cycle right after the in_eof byte.
  task automatic expect_ready(input string name);
    @(negedge clk_100_mhz);
    check({name, "_ready"}, {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic expect_drop(input string name);
    repeat (3) @(negedge clk_100_mhz);
    check({name, "_no_ready"}, {31'd0, rx_ready}, 32'd0);
    check({name, "_empty"}, {31'd0, rx_empty}, 32'd1);
  endtask

  task automatic drain_and_clear(input string name);
    int n;
    n = 0;
    while (!rx_empty && n < 8 * DEPTH) begin
      @(posedge clk_100_mhz); #1;
      rx_read_en = ($urandom_range(0, 3) != 0);
      n++;
    end
    // One extra pop while empty must be ignored.
    @(posedge clk_100_mhz); #1;
    rx_read_en = 1'b1;
    @(posedge clk_100_mhz); #1;
    rx_read_en = 1'b0;
    check({name, "_drain_empty"}, {31'd0, rx_empty}, 32'd1);
    check({name, "_drain_data"}, rx_data, 32'd0);
    check({name, "_drain_ready"}, {31'd0, rx_ready}, 32'd1);
    check({name, "_words_left"}, 32'(exp_words.size()), 32'd0);
    exp_words.delete();
    @(posedge clk_100_mhz); #1;
    rx_clear = 1'b1;
    @(posedge clk_100_mhz); #1;
    rx_clear      = 1'b0;
    model_holding = 1'b0;
    check({name, "_clr_ready"}, {31'd0, rx_ready}, 32'd0);
    check({name, "_clr_empty"}, {31'd0, rx_empty}, 32'd1);
    check({name, "_clr_count"}, {16'd0, rx_data_count}, 32'd0);
  endtask

  task automatic run_frame(input string name, input bit gaps);
    bit acc;
    acc = model_frame(1'b1, 1'b0);
    drive_frame(1'b1, 1'b0, gaps);
    if (acc) begin
      expect_ready(name);
      drain_and_clear(name);
    end else begin
      expect_drop(name);
    end
    check({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_overflow});
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1);
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    bit acc;
    int len;
    rst        = 1'b1;
    in_byte    = 8'd0;
    rx_read_en = 1'b0;
    idle_inputs();
    #1;
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_data", rx_data, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(posedge clk_100_mhz);
    #1 rst = 1'b0;

    // 64-byte frame filling the store exactly, EtherType 0x0800.
    build_seq(64);
    fb[12] = 8'h08;
    fb[13] = 8'h00;
    acc = model_frame(1'b1, 1'b0);
    drive_frame(1'b1, 1'b0, 1'b0);
    expect_ready("f64");
    check("f64_first_word", rx_data, 32'h03020100);
    check("f64_count", {16'd0, rx_data_count}, 32'd64);
    check("f64_type", rx_protocol_type, 32'h00000800);
    drain_and_clear("f64");

    // 15-byte frame: last word zero-padded.
    build_seq(15);
    acc = model_frame(1'b1, 1'b0);
    drive_frame(1'b1, 1'b0, 1'b0);
    expect_ready("f15");
    check("f15_count", {16'd0, rx_data_count}, 32'd15);
    drain_and_clear("f15");

    // 10-byte frame: runt, discarded.
    build_seq(10);
    run_frame("f10", 1'b0);

    // Second frame while holding is dropped; first frame intact.
    build_seq(20);
    fb[12] = 8'h86;
    fb[13] = 8'hDD;
    acc = model_frame(1'b1, 1'b0);
    drive_frame(1'b1, 1'b0, 1'b0);
    expect_ready("hold_a");
    build_rand(30);
    acc = model_frame(1'b1, 1'b0);
    drive_frame(1'b1, 1'b0, 1'b0);
    @(negedge clk_100_mhz);
    check("hold_still_ready", {31'd0, rx_ready}, 32'd1);
    check("hold_count", {16'd0, rx_data_count}, 32'd20);
    drain_and_clear("hold_a");

    // rx_clear together with in_sof: the whole frame is ignored.
    build_seq(20);
    acc = model_frame(1'b1, 1'b1);
    drive_frame(1'b1, 1'b1, 1'b0);
    expect_drop("clear_sof");

    // 65 bytes into a 64-byte store, then a normal frame.
    build_seq(65);
    run_frame("ovf65", 1'b0);
    check("ovf65_flag", {31'd0, overflow}, 32'd1);
    build_seq(20);
    run_frame("after_ovf", 1'b0);

    // Error on byte 5 of a 60-byte frame.
    build_seq(60);
    fe[5] = 1'b1;
    run_frame("err60", 1'b0);

    // Partial frame restarted by a new in_sof.
    build_rand(9);
    acc = model_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b0, 1'b0);
    build_rand(25);
    run_frame("restart", 1'b0);

    // Randomized frames: runts, normal, oversize, errored, restarted.
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        build_rand($urandom_range(1, 20));
        acc = model_frame(1'b0, 1'b0);
        drive_frame(1'b0, 1'b0, 1'b1);
      end
      len = $urandom_range(1, 70);
      build_rand(len);
      if ($urandom_range(0, 7) == 0) fe[$urandom_range(0, len - 1)] = 1'b1;
      run_frame("rand", 1'b1);
    end

    // Reset in the middle of a frame.
    check("overflow_sticky", {31'd0, overflow}, {31'd0, exp_overflow});
    build_rand(30);
    acc = model_frame(1'b0, 1'b0);
    drive_frame(1'b0, 1'b0, 1'b0);
    @(posedge clk_100_mhz);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
    check("mid_rst_empty", {31'd0, rx_empty}, 32'd1);
    check("mid_rst_data", rx_data, 32'd0);
    check("mid_rst_count", {16'd0, rx_data_count}, 32'd0);
    check("mid_rst_type", rx_protocol_type, 32'd0);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    exp_overflow  = 1'b0;
    model_holding = 1'b0;
    @(posedge clk_100_mhz);
    #1 rst = 1'b0;
    build_rand(40);
    run_frame("after_rst", 1'b1);

    check("frames_left", 32'(exp_frames.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
